shift_add_mul: RTL

SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

---
 rtl/shift_add_mul.sv | 88 ++++++++
 1 files changed

// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, LSB first,
// producing the low WIDTH bits of a*b after exactly WIDTH calculation cycles.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [CW-1:0]    cnt;
  logic             last_step;

  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign last_step = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The final step's sum goes straight into result so DONE follows the WIDTH-th edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          acc    <= acc_step;
          cnt    <= cnt + CW'(1);
          if (last_step) result <= acc_step;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == CALC);
  assign valid = (state == DONE);

endmodule
